// File: rtl/button_conditioner.sv
// Eight-channel push-button conditioner: synchroniser, debouncer, press strobe
// and rate-limited auto-repeat with opposing-direction cancellation.
module button_conditioner #(
  parameter int N_BUTTONS       = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES   = 200000,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_BUTTONS-1:0] btn_raw,
  output logic [N_BUTTONS-1:0] btn_level,
  output logic [N_BUTTONS-1:0] btn_press,
  output logic [N_BUTTONS-1:0] btn_move,
  output logic                 any_active
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);

  logic [N_BUTTONS-1:0] pol_s;
  logic [N_BUTTONS-1:0] sync1_r;
  logic [N_BUTTONS-1:0] sync2_r;
  logic [N_BUTTONS-1:0] level_r;
  logic [N_BUTTONS-1:0] press_r;
  logic [N_BUTTONS-1:0] move_r;
  logic [DW-1:0]        dcnt_r     [N_BUTTONS];
  logic [DW-1:0]        dcnt_nxt_s [N_BUTTONS];
  logic [RW-1:0]        rcnt_r     [N_BUTTONS];
  logic [RW-1:0]        rcnt_nxt_s [N_BUTTONS];
  logic [N_BUTTONS-1:0] level_nxt_s;
  logic [N_BUTTONS-1:0] press_nxt_s;
  logic [N_BUTTONS-1:0] event_s;
  logic [N_BUTTONS-1:0] move_nxt_s;

  assign pol_s = ACTIVE_LOW ? ~btn_raw : btn_raw;

  // Debounce: level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_comb begin
    level_nxt_s = level_r;
    for (int i = 0; i < N_BUTTONS; i++) begin
      dcnt_nxt_s[i] = '0;
      if (sync2_r[i] == level_r[i]) begin
        dcnt_nxt_s[i] = '0;
      end else if (dcnt_r[i] == D_LAST) begin
        level_nxt_s[i] = ~level_r[i];
        dcnt_nxt_s[i]  = '0;
      end else begin
        dcnt_nxt_s[i] = dcnt_r[i] + DW'(1);
      end
    end
  end

  // Auto-repeat; the partner's next level is used so same-cycle pair presses cancel
  always_comb begin
    press_nxt_s = level_nxt_s & ~level_r;
    event_s     = '0;
    move_nxt_s  = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      rcnt_nxt_s[i] = '0;
      if (press_nxt_s[i]) begin
        rcnt_nxt_s[i] = '0;
        event_s[i]    = 1'b1;
      end else if (level_nxt_s[i] && level_r[i]) begin
        if (rcnt_r[i] == R_LAST) begin
          rcnt_nxt_s[i] = '0;
          event_s[i]    = 1'b1;
        end else begin
          rcnt_nxt_s[i] = rcnt_r[i] + RW'(1);
          event_s[i]    = 1'b0;
        end
      end else begin
        rcnt_nxt_s[i] = '0;
        event_s[i]    = 1'b0;
      end
      move_nxt_s[i] = event_s[i] & ~level_nxt_s[i ^ 1];
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= '0;
      sync2_r <= '0;
      level_r <= '0;
      press_r <= '0;
      move_r  <= '0;
      for (int i = 0; i < N_BUTTONS; i++) begin
        dcnt_r[i] <= '0;
        rcnt_r[i] <= '0;
      end
    end else begin
      sync1_r <= pol_s;
      sync2_r <= sync1_r;
      level_r <= level_nxt_s;
      press_r <= press_nxt_s;
      move_r  <= move_nxt_s;
      for (int i = 0; i < N_BUTTONS; i++) begin
        dcnt_r[i] <= dcnt_nxt_s[i];
        rcnt_r[i] <= rcnt_nxt_s[i];
      end
    end
  end

  assign btn_level  = level_r;
  assign btn_press  = press_r;
  assign btn_move   = move_r;
  assign any_active = |level_r;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: an active-high and an active-low instance are
// driven with complementary pins and both checked against one reference model.
module tb_button_conditioner;

  localparam int NB = 8;
  localparam int D  = 4;
  localparam int R  = 5;
  localparam int HOFF = 8;

  logic          clk;
  logic          rst_n;
  logic [NB-1:0] raw_a, raw_b;
  logic [NB-1:0] level_a, press_a, move_a;
  logic [NB-1:0] level_b, press_b, move_b;
  logic          any_a, any_b;

  int compared;
  int mismatched;

  // reference model state
  logic [NB-1:0] ph [0:4095];
  int            n;
  logic [NB-1:0] lvl_m, press_m, move_m;
  int            t_m [NB];

  button_conditioner #(.N_BUTTONS(NB), .DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R),
                       .ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst_n(rst_n), .btn_raw(raw_a), .btn_level(level_a),
    .btn_press(press_a), .btn_move(move_a), .any_active(any_a));

  button_conditioner #(.N_BUTTONS(NB), .DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R),
                       .ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst_n(rst_n), .btn_raw(raw_b), .btn_level(level_b),
    .btn_press(press_b), .btn_move(move_b), .any_active(any_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h at edge %0d", tag, obs, exp, n);
    end
  endtask

  task automatic chk_all(input logic [NB-1:0] lv, input logic [NB-1:0] pr,
                         input logic [NB-1:0] mv, input logic an);
    chk("level_hi", level_a, lv);
    chk("press_hi", press_a, pr);
    chk("move_hi",  move_a,  mv);
    chk("any_hi",   {7'b0, any_a}, {7'b0, an});
    chk("level_lo", level_b, lv);
    chk("press_lo", press_b, pr);
    chk("move_lo",  move_b,  mv);
    chk("any_lo",   {7'b0, any_b}, {7'b0, an});
  endtask

  task automatic model_reset();
    for (int j = 0; j < 4096; j++) ph[j] = '0;
    n       = 0;
    lvl_m   = '0;
    press_m = '0;
    move_m  = '0;
    for (int b = 0; b < NB; b++) t_m[b] = 0;
  endtask

  // One clock: drive pressed-pattern r, advance the model by one edge, check.
  task automatic tick(input logic [NB-1:0] r);
    logic [NB-1:0] prev;
    logic          all_diff;
    logic          ev;
    raw_a = r;
    raw_b = ~r;
    @(posedge clk);
    n++;
    ph[n + HOFF] = r;
    prev = lvl_m;
    // level flips once the pin has disagreed for D samples, seen two edges late
    for (int b = 0; b < NB; b++) begin
      all_diff = 1'b1;
      for (int j = n - 1 - D; j <= n - 2; j++)
        if (ph[j + HOFF][b] == lvl_m[b]) all_diff = 1'b0;
      if (all_diff) lvl_m[b] = ~lvl_m[b];
    end
    press_m = lvl_m & ~prev;
    for (int b = 0; b < NB; b++) begin
      if (press_m[b]) begin
        ev = 1'b1;
        t_m[b] = n;
      end else if (lvl_m[b] && prev[b]) begin
        ev = ((n - t_m[b]) % R) == 0;
      end else begin
        ev = 1'b0;
      end
      move_m[b] = ev & ~lvl_m[b ^ 1];
    end
    @(negedge clk);
    chk_all(lvl_m, press_m, move_m, |lvl_m);
  endtask

  task automatic hold(input logic [NB-1:0] r, input int cycles);
    for (int c = 0; c < cycles; c++) tick(r);
  endtask

  initial begin
    logic [NB-1:0] pat;
    int            len;
    int            bb;
    compared   = 0;
    mismatched = 0;
    model_reset();
    rst_n = 1'b0;
    raw_a = 8'hFF;
    raw_b = 8'h00;

    // reset held with all pins pressed: outputs stay clear
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk_all(8'h00, 8'h00, 8'h00, 1'b0);
    end
    rst_n = 1'b1;
    model_reset();

    hold(8'hFF, 12);
    hold(8'h00, 8);

    // bounce on bit0 (2-cycle pulses never survive debounce), then a clean hold
    for (int c = 0; c < 20; c++) begin
      pat = ((c / 2) % 2 == 0) ? 8'h01 : 8'h00;
      tick(pat);
    end
    hold(8'h01, 10);
    hold(8'h00, 8);

    // auto-repeat on bit4
    hold(8'h10, 36);
    hold(8'h00, 8);

    // pair conflict, then partner release
    hold(8'h03, 12);
    hold(8'h01, 15);
    hold(8'h00, 8);

    // bit7 (pin low on the active-low instance)
    hold(8'h80, 20);
    hold(8'h00, 8);

    // asynchronous reset between edges while bit2 is held and repeating
    hold(8'h04, 20);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all(8'h00, 8'h00, 8'h00, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_all(8'h00, 8'h00, 8'h00, 1'b0);
    end
    rst_n = 1'b1;
    model_reset();
    hold(8'h04, 15);
    hold(8'h00, 8);

    // randomized segments: random held patterns and short glitch bursts
    for (int s = 0; s < 60; s++) begin
      pat = 8'($urandom);
      len = $urandom_range(1, 25);
      if ($urandom_range(0, 3) == 0) begin
        bb = $urandom_range(0, NB - 1);
        for (int c = 0; c < len; c++) begin
          pat[bb] = ~pat[bb];
          tick(pat);
        end
      end else begin
        hold(pat, len);
      end
    end
    hold(8'h00, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
